mem_access_unit: RTL

- Parametrised successor to the datapath's MAR/MDR/memory path.
- Holds the MAR and MDR registers and owns a request/acknowledge handshake to a variable-latency memory.
- Wait states, Busy and Done status are exposed to the control unit.
- Sits between the datapath bus and the RAM; MDR drives the bus mux, and the bus loads MAR/MDR.

---
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR register pair plus request/acknowledge handshake
// to a variable-latency memory. Status (Busy/Done/Err) goes to the control unit.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a REQ phase that
// lasts TIMEOUT cycles without an acknowledge is aborted and Err is raised.
// When it is undefined, REQ waits indefinitely and Err is tied low.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [DATA_W-1:0] BusIn,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] MAR_data_out,
  output logic [DATA_W-1:0] MDR_data_out,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              accept;
  logic              timeout_hit;

  // Reject parameter sets that cannot work (address wider than bus, no timeout window)
  if (ADDR_W > DATA_W || TIMEOUT < 1) begin : g_param_check
    $error("mem_access_unit: ADDR_W must be <= DATA_W and TIMEOUT must be >= 1");
  end

  // A new transaction is taken only from IDLE; Read/Write while busy are dropped
  assign accept = (state == ST_IDLE) && (Read || Write);

  // The memory sees the registers directly, so the bus never reaches memory combinationally
  assign mem_addr     = mar;
  assign mem_wdata    = mdr;
  assign MAR_data_out = DATA_W'(mar);
  assign MDR_data_out = mdr;

`ifdef MEM_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;

  // An acknowledge in the final allowed cycle still wins over the abort
  assign timeout_hit = (state == ST_REQ) && !mem_ack && (wait_cnt == CNT_LAST);

  // Count REQ cycles spent waiting for the memory; restart on every accepted transaction
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state == ST_REQ && !mem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error: raised by an abort, cleared only by the next accepted request
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      Err <= 1'b0;
    end else if (accept) begin
      Err <= 1'b0;
    end else if (timeout_hit) begin
      Err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign Err         = 1'b0;
`endif

  // Handshake FSM with registered status outputs and the MAR/MDR registers it guards
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state   <= ST_IDLE;
      mar     <= '0;
      mdr     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (MARin) begin
            mar <= BusIn[ADDR_W-1:0];
          end
          if (MDRin) begin
            mdr <= BusIn;
          end
          if (accept) begin
            state   <= ST_REQ;
            Busy    <= 1'b1;
            mem_req <= 1'b1;
            mem_we  <= Write & ~Read;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            Done    <= 1'b1;
            if (!mem_we) begin
              mdr <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            Done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
